// File: rtl/conv_output_writer.sv
// Buffers per-pixel convolution results in a small FIFO and streams them onto the
// output SRAM write port at consecutive addresses, signalling matrix completion.
module conv_output_writer #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic              addr_clear,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_last,
    output logic              res_ready,
    input  logic              wr_hold,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic              busy,
    output logic              mat_done,
    output logic [ADDR_W-1:0] wr_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] waddr;
    logic              push, pop;

    // Ready depends on registered state only, so a pop in the same cycle cannot reopen it.
    assign res_ready = (state == S_STREAM) && (count < CNT_W'(DEPTH));
    assign push      = res_valid && res_ready;
    assign pop       = (count != '0) && !wr_hold;
    assign busy      = (state == S_STREAM) || (state == S_DRAIN);
    assign mat_done  = (state == S_DONE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_STREAM;
            S_STREAM: if (push && res_last) state_next = S_DRAIN;
            S_DRAIN:  if (count == '0) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= res_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state                  <= S_IDLE;
            head                   <= '0;
            tail                   <= '0;
            count                  <= '0;
            waddr                  <= BASE_ADDR;
            wr_count               <= '0;
            dut_sram_write_enable  <= 1'b0;
            dut_sram_write_address <= BASE_ADDR;
            dut_sram_write_data    <= '0;
        end else begin
            state                 <= state_next;
            count                 <= count + CNT_W'(push) - CNT_W'(pop);
            dut_sram_write_enable <= pop;
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head                   <= head + PTR_W'(1);
                dut_sram_write_data    <= fifo_mem[head];
                dut_sram_write_address <= waddr;
                waddr                  <= waddr + ADDR_W'(1);
            end
            // The FIFO is always empty in IDLE, so these never collide with a pop.
            if (state == S_IDLE && start) begin
                wr_count <= '0;
            end else if (pop) begin
                wr_count <= wr_count + ADDR_W'(1);
            end
            if (state == S_IDLE && !start && addr_clear) begin
                waddr <= BASE_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_conv_output_writer.sv
// Directed bench for conv_output_writer: a queue-based reference model checked every
// cycle, plus literal expectations on addresses, data, latency and completion.
module tb_conv_output_writer;

    localparam int          ADDR_W = 12;
    localparam int          DATA_W = 16;
    localparam int          DEPTH  = 4;
    localparam logic [11:0] BASE   = 12'h000;

    logic              clk;
    logic              reset_b;
    logic              start;
    logic              addr_clear;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              res_ready;
    logic              wr_hold;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;
    logic              busy;
    logic              mat_done;
    logic [ADDR_W-1:0] wr_count;

    conv_output_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .addr_clear(addr_clear),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .res_ready(res_ready), .wr_hold(wr_hold),
        .dut_sram_write_address(dut_sram_write_address),
        .dut_sram_write_data(dut_sram_write_data),
        .dut_sram_write_enable(dut_sram_write_enable),
        .busy(busy), .mat_done(mat_done), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase of the matrix, queue of words accepted but not yet written.
    typedef enum {M_IDLE, M_STREAM, M_DRAIN, M_DONE} phase_t;
    phase_t      ph = M_IDLE;
    logic [15:0] q[$];
    logic [11:0] m_addr = BASE;
    logic [11:0] m_cnt = '0;
    logic        e_we = 1'b0;
    logic [11:0] e_addr = BASE;
    logic [15:0] e_data = '0;
    bit          m_rdy, m_push, m_pop, m_empty;
    bit          armed = 1'b0;
    int          cyc = 0;

    logic [11:0] log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];
    int          done_pulses = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset_b) begin
                armed  = 1'b1;
                ph     = M_IDLE;
                q.delete();
                m_addr = BASE;
                m_cnt  = '0;
                e_we   = 1'b0;
                e_addr = BASE;
                e_data = '0;
            end else if (armed) begin
                m_rdy   = (ph == M_STREAM) && (q.size() < DEPTH);
                m_push  = res_valid && m_rdy;
                m_pop   = (q.size() > 0) && !wr_hold;
                m_empty = (q.size() == 0);
                e_we    = m_pop;
                if (m_pop) begin
                    e_data = q.pop_front();
                    e_addr = m_addr;
                    m_addr = m_addr + 12'd1;
                    m_cnt  = m_cnt + 12'd1;
                end
                if (m_push) q.push_back(res_data);
                case (ph)
                    M_IDLE: begin
                        if (start) begin
                            ph    = M_STREAM;
                            m_cnt = '0;
                        end else if (addr_clear) begin
                            m_addr = BASE;
                        end
                    end
                    M_STREAM: if (m_push && res_last) ph = M_DRAIN;
                    M_DRAIN:  if (m_empty) ph = M_DONE;
                    M_DONE:   ph = M_IDLE;
                endcase
            end
            #1;
            if (armed) begin
                chk("we", dut_sram_write_enable, e_we);
                chk("addr", dut_sram_write_address, e_addr);
                chk("data", dut_sram_write_data, e_data);
                chk("ready", res_ready, (ph == M_STREAM) && (q.size() < DEPTH));
                chk("busy", busy, (ph == M_STREAM) || (ph == M_DRAIN));
                chk("mat_done", mat_done, ph == M_DONE);
                chk("wr_count", wr_count, m_cnt);
                if (dut_sram_write_enable === 1'b1) begin
                    log_addr.push_back(dut_sram_write_address);
                    log_data.push_back(dut_sram_write_data);
                    log_cyc.push_back(cyc);
                end
                if (mat_done === 1'b1) done_pulses++;
            end
        end
    end

    function automatic logic [31:0] la(input int i);
        if (i < log_addr.size()) return 32'(log_addr[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ld(input int i);
        if (i < log_data.size()) return 32'(log_data[i]);
        return 32'hFFFF_FFFF;
    endfunction

    int  held_accepts = 0;
    bit  hs_seen = 1'b0;
    int  hs_cyc = 0;

    // Called at a falling edge; returns at the falling edge after the handshake edge.
    task automatic send(input logic [15:0] d, input logic last);
        int n = 0;
        res_valid = 1'b1;
        res_data  = d;
        res_last  = last;
        while (res_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (res_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready_low required=handshake data=%0h", d);
        end else begin
            if (wr_hold) held_accepts++;
            if (!hs_seen) begin
                hs_seen = 1'b1;
                hs_cyc  = cyc + 1;
            end
        end
        @(negedge clk);
        res_valid = 1'b0;
        res_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (mat_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mat_done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_mat_done required=mat_done");
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        addr_clear = 1'b1;
        @(negedge clk);
        addr_clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    int n0, dp0;

    initial begin
        reset_b = 1'b1; start = 1'b0; addr_clear = 1'b0;
        res_valid = 1'b0; res_data = '0; res_last = 1'b0; wr_hold = 1'b0;
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
        chk("rst_we", dut_sram_write_enable, 0);
        chk("rst_addr", dut_sram_write_address, 12'h000);
        chk("rst_data", dut_sram_write_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", res_ready, 0);
        chk("rst_wr_count", wr_count, 0);

        // Nine back-to-back words
        n0 = log_addr.size(); dp0 = done_pulses; hs_seen = 1'b0;
        pulse_start();
        chk("t1_busy", busy, 1);
        for (int i = 1; i <= 9; i++) send(16'(i), i == 9);
        wait_done();
        chk("t1_writes", log_addr.size() - n0, 9);
        for (int i = 0; i < 9; i++) begin
            chk("t1_addr", la(n0 + i), i);
            chk("t1_data", ld(n0 + i), i + 1);
        end
        chk("t1_latency", (log_cyc.size() > n0) ? log_cyc[n0] - hs_cyc : -1, 1);
        chk("t1_wr_count", wr_count, 9);
        chk("t1_done_pulses", done_pulses - dp0, 1);
        chk("t1_busy_low", busy, 0);

        // Hold for six cycles while streaming; address carries on from 9
        n0 = log_addr.size(); held_accepts = 0;
        pulse_start();
        wr_hold = 1'b1;
        fork
            begin
                repeat (6) @(negedge clk);
                wr_hold = 1'b0;
            end
            begin
                for (int i = 1; i <= 8; i++) send(16'h0100 + 16'(i), i == 8);
            end
        join
        wait_done();
        chk("t2_held_accepts", held_accepts, 4);
        chk("t2_writes", log_addr.size() - n0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_addr", la(n0 + i), 9 + i);
            chk("t2_data", ld(n0 + i), 32'h0101 + i);
        end
        chk("t2_wr_count", wr_count, 8);

        // addr_clear in IDLE restarts at BASE
        pulse_clear();
        n0 = log_addr.size();
        pulse_start();
        send(16'h0201, 1'b0);
        send(16'h0202, 1'b1);
        wait_done();
        chk("t3_addr0", la(n0), 12'h000);
        chk("t3_addr1", la(n0 + 1), 12'h001);

        // 4094 words bring the address to FFE, then wrap
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 4094; i++) send(16'(i), i == 4093);
        wait_done();
        chk("t4_big_count", wr_count, 12'hFFE);
        n0 = log_addr.size();
        pulse_start();
        for (int i = 1; i <= 3; i++) send(16'h0A00 + 16'(i), i == 3);
        wait_done();
        chk("t4_addr_ffe", la(n0), 12'hFFE);
        chk("t4_addr_fff", la(n0 + 1), 12'hFFF);
        chk("t4_addr_000", la(n0 + 2), 12'h000);
        chk("t4_data_last", ld(n0 + 2), 16'h0A03);

        // res_valid in IDLE, start+addr_clear together, start during STREAM: all ignored extras
        n0 = log_addr.size();
        res_valid = 1'b1; res_data = 16'hBEEF;
        repeat (3) @(negedge clk);
        res_valid = 1'b0;
        addr_clear = 1'b1;
        pulse_start();
        addr_clear = 1'b0;
        send(16'h0301, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(16'h0302, 1'b1);
        wait_done();
        chk("t5_writes", log_addr.size() - n0, 2);
        chk("t5_addr0", la(n0), 12'h001);
        chk("t5_data0", ld(n0), 16'h0301);
        chk("t5_data1", ld(n0 + 1), 16'h0302);
        chk("t5_wr_count", wr_count, 2);

        // Reset with three words buffered
        pulse_start();
        wr_hold = 1'b1;
        for (int i = 1; i <= 3; i++) send(16'h0500 + 16'(i), 1'b0);
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        wr_hold = 1'b0;
        n0 = log_addr.size();
        chk("t6_we", dut_sram_write_enable, 0);
        chk("t6_addr", dut_sram_write_address, BASE);
        chk("t6_data", dut_sram_write_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", res_ready, 0);
        chk("t6_wr_count", wr_count, 0);
        repeat (4) @(negedge clk);
        chk("t6_no_writes", log_addr.size() - n0, 0);
        pulse_start();
        send(16'h0601, 1'b0);
        send(16'h0602, 1'b1);
        wait_done();
        chk("t6_new_addr0", la(n0), 12'h000);
        chk("t6_new_data1", ld(n0 + 1), 16'h0602);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
